div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 signed_div_i  input  1  1 = signed division, 0 = unsigned.
REQ-004 opdata1_i  input  32  dividend.
REQ-005 opdata2_i  input  32  divisor.
REQ-006 start_i  input  1  request from EX stage; held high while EX stalls on the divide.
REQ-007 annul_i  input  1  cancel in-flight divide (pipeline flush).
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-009 ready_o  output  1  result_o valid, registered.

Function
REQ-010 SHALL implement an FSM with states FREE, BYZERO, ON, END.
REQ-011 FREE: start_i=1 and annul_i=0 SHALL latch operands and signed_div_i. Next state is BYZERO if divisor=0, otherwise ON with cnt=0.
REQ-012 Operand changes after the latch cycle SHALL NOT affect the result.
REQ-013 Signed mode: negative operands SHALL be converted to magnitude at latch time.
REQ-014 ON: one restoring shift-subtract step per cycle, producing one quotient bit per step; cnt increments 0..31.
REQ-015 At cnt=32 the FSM SHALL apply the sign fix and go to END.
REQ-016 Sign fix: quotient negated if dividend sign differs from divisor sign; remainder takes the dividend's sign. Unsigned mode has no sign fix.
REQ-017 BYZERO: SHALL go to END with result 0x0 on the next edge.
REQ-018 END: ready_o=1, result_o held stable while start_i=1. start_i=0 SHALL return to FREE with ready_o=0 and result_o=0.
REQ-019 Latency, measured from the edge sampling start_i to the first cycle with ready_o=1: normal 34 cycles, divide-by-zero 2 cycles.
REQ-020 annul_i=1 in any state SHALL force FREE on the next edge, with ready_o=0 and result_o=0; the partial result is discarded.
REQ-021 annul_i and start_i both high in FREE: annul wins; no divide starts.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wraps, no trap).
REQ-023 Outside END, ready_o SHALL be 0 and result_o SHALL be 0.

Reset
REQ-024 rst=0 SHALL immediately force FREE, cnt=0, ready_o=0, result_o=0, and clear the latched operands, including mid-operation.
REQ-025 After rst is released, the first start_i SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro DIV_EARLY_EXIT_EN.
- Defined: in FREE on start, if divisor≠0 and |dividend| < |divisor| (unsigned magnitudes), the block SHALL go directly to END with quotient 0 and remainder = the original signed/unsigned dividend. Latency is 1 cycle.
- Undefined: all non-zero-divisor divides SHALL take the full 34-cycle path.
- Results SHALL be identical in both builds.

Structure
REQ-027 Constants SHALL live in the shared defines file:
- state encodings DivFree, DivByZero, DivOn, DivEnd;
- DivResultReady / DivResultNotReady;
- DivStart / DivStop.
REQ-028 Single module, no sub-module. The 33-bit trial subtract is inline combinational logic feeding the state register.
REQ-029 EX-side integration (EX muxes the operands, drives stallreq from ready_o, writes result_o into HI/LO) is outside this block.

Verification
REQ-030 Unsigned 0xFFFFFFFF/0x00000002 -> after 34 cycles: ready_o=1, result_o=0x00000001_7FFFFFFF.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD.
REQ-032 Signed 7/-2 -> result_o=0x00000001_FFFFFFFD.
REQ-033 Any dividend / 0 -> ready_o=1 after 2 cycles, result_o=0.
REQ-034 annul_i pulsed at cnt=10 -> FREE next edge, ready_o stays 0. An immediate new start of 100/7 -> result_o=0x00000002_0000000E.
REQ-035 rst=0 at cnt=20 -> outputs 0 asynchronously. With DIV_EARLY_EXIT_EN defined, 3/9 -> ready_o after 1 cycle, result_o=0x00000003_00000000.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants, state type and helpers for the div block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

   localparam logic [1:0] DivFree           = 2'b00;
   localparam logic [1:0] DivByZero         = 2'b01;
   localparam logic [1:0] DivOn             = 2'b10;
   localparam logic [1:0] DivEnd            = 2'b11;

   localparam logic       DivResultReady    = 1'b1;
   localparam logic       DivResultNotReady = 1'b0;

   localparam logic       DivStart          = 1'b1;
   localparam logic       DivStop           = 1'b0;

   localparam int         DATA_W            = 32;
   localparam logic [5:0] DIV_STEPS         = 6'd32;

   typedef enum logic [1:0] {
      S_FREE   = DivFree,
      S_BYZERO = DivByZero,
      S_ON     = DivOn,
      S_END    = DivEnd
   } div_state_e;

   // Magnitude of an operand; only negative values in signed mode change.
   function automatic logic [DATA_W-1:0] div_mag(input logic [DATA_W-1:0] v,
                                                 input logic              is_signed);
      return (is_signed && v[DATA_W-1]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [DATA_W-1:0] div_neg_if(input logic [DATA_W-1:0] v,
                                                    input logic              neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
//  Module      : div
//  Description : 32-bit signed/unsigned restoring divider, one quotient bit per
//                cycle. Optional DIV_EARLY_EXIT_EN finishes |a| < |b| at once.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div
   import div_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   div_state_e          state_q,   state_d;
   logic [5:0]          cnt_q,     cnt_d;
   logic [DATA_W-1:0]   rem_q,     rem_d;
   logic [DATA_W-1:0]   quo_q,     quo_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0] result_q,  result_d;
   logic                ready_q,   ready_d;

   logic [DATA_W:0]     w_minuend;
   logic                w_ge;
   logic [DATA_W-1:0]   w_trial;
   logic [DATA_W-1:0]   w_mag1;
   logic [DATA_W-1:0]   w_mag2;

   // Quotient register doubles as the dividend shifter: its MSB feeds the
   // partial remainder each step while the new quotient bit enters the LSB.
   // A non-negative difference is below the divisor, so 32 bits suffice.
   assign w_minuend = {rem_q, quo_q[DATA_W-1]};
   assign w_ge      = (w_minuend >= {1'b0, divisor_q});
   assign w_trial   = w_minuend[DATA_W-1:0] - divisor_q;

   assign w_mag1    = div_mag(opdata1_i, signed_div_i);
   assign w_mag2    = div_mag(opdata2_i, signed_div_i);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      if (annul_i) begin
         state_d  = S_FREE;
         cnt_d    = 6'd0;
         result_d = '0;
         ready_d  = DivResultNotReady;
      end else begin
         case (state_q)
            S_FREE: begin
               result_d = '0;
               ready_d  = DivResultNotReady;
               if (start_i == DivStart) begin
                  if (opdata2_i == '0) begin
                     state_d = S_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
                  end else if (w_mag1 < w_mag2) begin
                     state_d  = S_END;
                     result_d = {opdata1_i, {DATA_W{1'b0}}};
                     ready_d  = DivResultReady;
`endif
                  end else begin
                     state_d   = S_ON;
                     cnt_d     = 6'd0;
                     rem_d     = '0;
                     quo_d     = w_mag1;
                     divisor_d = w_mag2;
                     neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                  end
               end
            end

            S_BYZERO: begin
               state_d  = S_END;
               result_d = '0;
               ready_d  = DivResultReady;
            end

            S_ON: begin
               if (cnt_q == DIV_STEPS) begin
                  state_d  = S_END;
                  result_d = {div_neg_if(rem_q, neg_rem_q), div_neg_if(quo_q, neg_quo_q)};
                  ready_d  = DivResultReady;
               end else begin
                  rem_d = w_ge ? w_trial : w_minuend[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], w_ge};
                  cnt_d = cnt_q + 6'd1;
               end
            end

            S_END: begin
               if (start_i == DivStop) begin
                  state_d  = S_FREE;
                  cnt_d    = 6'd0;
                  result_d = '0;
                  ready_d  = DivResultNotReady;
               end
            end

            default: begin
               state_d  = S_FREE;
               cnt_d    = 6'd0;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FREE;
         cnt_q     <= 6'd0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
//  Module      : tb_div
//  Description : Directed self-checking bench for div (DIV_EARLY_EXIT_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div;

`ifdef DIV_EARLY_EXIT_EN
   localparam int LAT_SMALL = 1;
`else
   localparam int LAT_SMALL = 34;
`endif

   logic        clk          = 1'b0;
   logic        rst          = 1'b0;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i    = '0;
   logic [31:0] opdata2_i    = '0;
   logic        start_i      = 1'b0;
   logic        annul_i      = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_pass   = 0;

   div u_dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
   endtask

   // Issues one divide, scrambles the operands after the latch edge, checks
   // latency, result, hold behaviour in END and the return to idle.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      lat          = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         lat = i;
         if (i == 1) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sgn;
         end
         if (ready_o) break;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, result_o, exp_res);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " idle"}, result_o | 64'(ready_o), 64'd0);
   endtask

   initial begin
      logic seen;

      #3;
      check("reset outputs", result_o | 64'(ready_o), 64'd0);
      #10;
      @(negedge clk);
      rst = 1'b1;

      run_div("u ffffffff/2", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_7FFF_FFFF, 34);
      run_div("s -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
      run_div("s 7/-2",       1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34);
      run_div("div by zero",  1'b1, 32'h1234_5678, 32'd0, 64'd0, 2);
      run_div("s min/-1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34);
      run_div("u 80000000/2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0000_4000_0000, 34);
      run_div("u 3/9",        1'b0, 32'd3, 32'd9, 64'h0000_0003_0000_0000, LAT_SMALL);
      run_div("s -3/9",       1'b1, 32'hFFFF_FFFD, 32'd9, 64'hFFFF_FFFD_0000_0000, LAT_SMALL);

      // Annul beats start in FREE: nothing may complete afterwards.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      annul_i      = 1'b1;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      start_i = 1'b0;
      seen    = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= ready_o;
      end
      check("annul+start no ready", 64'(seen), 64'd0);

      // Annul at cnt=10, then an immediate new divide.
      @(negedge clk);
      opdata1_i = 32'd100000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      check("annul outputs", result_o | 64'(ready_o), 64'd0);
      run_div("u 100/7 after annul", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34);

      // Reset at cnt=20, then the first start after release must be taken.
      @(negedge clk);
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      repeat (21) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("reset mid-op", result_o | 64'(ready_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div("u 1000/3 after reset", 1'b0, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 34);

      // Asynchronous clear while a result is being presented.
      @(negedge clk);
      opdata1_i = 32'd50;
      opdata2_i = 32'd0;
      start_i   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("byzero ready before async reset", 64'(ready_o), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async reset in END", result_o | 64'(ready_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
